xgemac_wb_ctrl: RTL and testbench

Wishbone bus controller for the xge_mac register block. It runs the post-reset configuration sequence (config register, interrupt mask) and then services `wb_int_o` by reading the clear-on-read interrupt-pending register. It also shares the single Wishbone slave port between that internal sequencer and an external host request port. It sits between the test/host side and the MAC's `wb_*` pins, in the `wb_clk_i` domain.

---
 rtl/xgemac_wb_ctrl.sv | 162 ++++++++++++++++
 tb/tb_xgemac_wb_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgemac_wb_ctrl.sv
// Wishbone master for the xge_mac register block: post-reset init writes,
// interrupt-pending service and round-robin sharing with a host port.
module xgemac_wb_ctrl #(
  parameter logic [7:0]  CFG_ADR     = 8'h00,
  parameter logic [31:0] CFG_VAL     = 32'h0000_0001,
  parameter logic [7:0]  MASK_ADR    = 8'h10,
  parameter logic [31:0] MASK_VAL    = 32'h0000_01FF,
  parameter logic [7:0]  PEND_ADR    = 8'h08,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_int_i,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_adr,
  input  logic [31:0] host_wdat,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] host_rdat,
  output logic        cfg_done,
  output logic [31:0] int_pend,
  output logic [15:0] int_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    CFG_WR, CFG_GAP, MASK_WR, IDLE,
    HOST_CYC, INT_CYC, GAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_tmo;
  logic        r_last_int;
  logic        r_hwe;
  logic [7:0]  r_hadr;
  logic [31:0] r_hdat;

  logic [7:0]  w_adr;
  logic [31:0] w_dat;
  logic        w_we;
  logic        w_tmo;

  assign w_tmo = (r_tmo == 16'(ACK_TIMEOUT - 1));

  // Bus fields presented when a bus state raises stb
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_we  = 1'b0;
    unique case (r_state)
      CFG_WR: begin
        w_adr = CFG_ADR;
        w_dat = CFG_VAL;
        w_we  = 1'b1;
      end
      MASK_WR: begin
        w_adr = MASK_ADR;
        w_dat = MASK_VAL;
        w_we  = 1'b1;
      end
      HOST_CYC: begin
        w_adr = r_hadr;
        w_dat = r_hdat;
        w_we  = r_hwe;
      end
      INT_CYC: w_adr = PEND_ADR;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= CFG_WR;
      r_tmo       <= '0;
      r_last_int  <= 1'b1;
      r_hwe       <= 1'b0;
      r_hadr      <= '0;
      r_hdat      <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      host_ack    <= 1'b0;
      host_err    <= 1'b0;
      host_rdat   <= '0;
      cfg_done    <= 1'b0;
      int_pend    <= '0;
      int_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      unique case (r_state)
        CFG_GAP: r_state <= MASK_WR;
        GAP:     r_state <= IDLE;
        IDLE: begin
          // Host wins unless interrupt is also up and host went last
          if (host_req && (!wb_int_i || r_last_int)) begin
            r_state    <= HOST_CYC;
            r_last_int <= 1'b0;
            r_hwe      <= host_we;
            r_hadr     <= host_adr;
            r_hdat     <= host_wdat;
          end else if (wb_int_i) begin
            r_state    <= INT_CYC;
            r_last_int <= 1'b1;
          end
        end
        default: begin
          if (!wb_stb_o) begin
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_adr_o <= w_adr;
            wb_dat_o <= w_dat;
            wb_we_o  <= w_we;
            r_tmo    <= '0;
          end else if (wb_ack_i || w_tmo) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            if (!wb_ack_i)
              timeout_err <= 1'b1;
            unique case (r_state)
              CFG_WR: r_state <= CFG_GAP;
              MASK_WR: begin
                cfg_done <= 1'b1;
                r_state  <= GAP;
              end
              HOST_CYC: begin
                host_ack <= 1'b1;
                host_err <= !wb_ack_i;
                if (wb_ack_i && !r_hwe)
                  host_rdat <= wb_dat_i;
                r_state <= GAP;
              end
              INT_CYC: begin
                if (wb_ack_i) begin
                  int_pend <= wb_dat_i;
                  if (int_cnt != 16'hFFFF)
                    int_cnt <= int_cnt + 16'd1;
                end
                r_state <= GAP;
              end
              default: r_state <= IDLE;
            endcase
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgemac_wb_ctrl.sv
// Randomized bench for xgemac_wb_ctrl: Wishbone slave/monitor plus a
// transaction-level model of init, arbitration and timeout behaviour.
module tb_xgemac_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_int_i = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_adr = '0;
  logic [31:0] host_wdat = '0;
  logic        host_ack, host_err;
  logic [31:0] host_rdat;
  logic        cfg_done;
  logic [31:0] int_pend;
  logic [15:0] int_cnt;
  logic        timeout_err;

  always #5 clk = ~clk;

  xgemac_wb_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i),
    .host_req(host_req), .host_we(host_we),
    .host_adr(host_adr), .host_wdat(host_wdat),
    .host_ack(host_ack), .host_err(host_err),
    .host_rdat(host_rdat), .cfg_done(cfg_done),
    .int_pend(int_pend), .int_cnt(int_cnt),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [7:0]  adr;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    bit          tmo;
    int          len;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  int          slv_wait = 0;
  bit          slv_noack = 0;
  logic [31:0] slv_rdat = '0;
  txn_t        txq[$];
  int          hack_n = 0;
  logic        last_err = 1'b0;
  int          cyc_bad = 0;

  logic [31:0] m_rdat, m_pend;
  int          m_cnt;
  bit          m_last_int, m_terr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave and monitor: all observation happens on the falling edge
  initial begin
    int wcnt, hi_len;
    bit stb_prev;
    wcnt = 0; hi_len = 0; stb_prev = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_ack_i = 1'b0;
        wcnt = 0; hi_len = 0; stb_prev = 0;
      end else begin
        if (wb_cyc_o !== wb_stb_o) cyc_bad++;
        if (host_ack) begin
          hack_n++;
          last_err = host_err;
        end
        if (wb_ack_i) begin
          txq.push_back('{wb_adr_o, wb_we_o, wb_dat_o,
                          wb_dat_i, 1'b0, hi_len});
          wb_ack_i = 1'b0;
          hi_len = 0; wcnt = 0;
        end else if (stb_prev && !wb_stb_o) begin
          txq.push_back('{wb_adr_o, wb_we_o, wb_dat_o,
                          32'h0, 1'b1, hi_len});
          hi_len = 0; wcnt = 0;
        end
        if (wb_stb_o) begin
          hi_len++;
          if (!slv_noack) begin
            if (wcnt == slv_wait) begin
              wb_ack_i = 1'b1;
              wb_dat_i = slv_rdat;
            end else wcnt++;
          end
        end
        stb_prev = wb_stb_o;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_rdat = '0; m_pend = '0; m_cnt = 0;
    m_last_int = 1; m_terr = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdat"}, host_rdat, m_rdat);
    check({tag, "_pend"}, int_pend, m_pend);
    check({tag, "_cnt"}, int_cnt, m_cnt);
    check({tag, "_terr"}, timeout_err, m_terr);
  endtask

  task automatic release_and_init();
    bit done;
    done = 0;
    txq.delete();
    slv_wait = 0; slv_noack = 0;
    rst = 1'b0;
    step(1);
    check("init_stb_rise", wb_stb_o, 1);
    check("init_adr0", wb_adr_o, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (cfg_done) begin
        done = 1;
        break;
      end
      step(1);
    end
    check("init_done", done, 1);
    check("init_n", txq.size(), 2);
    if (txq.size() == 2) begin
      check("init_w0_adr", txq[0].adr, 8'h00);
      check("init_w0_dat", txq[0].wdat, 32'h1);
      check("init_w0_we", txq[0].we, 1);
      check("init_w1_adr", txq[1].adr, 8'h10);
      check("init_w1_dat", txq[1].wdat, 32'h1FF);
      check("init_w1_we", txq[1].we, 1);
    end
  endtask

  task automatic host_op(input bit we, input logic [7:0] adr,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int ws, input bit noack);
    int h0;
    bit done;
    h0 = hack_n; done = 0;
    slv_wait = ws; slv_noack = noack; slv_rdat = rd;
    txq.delete();
    host_we = we; host_adr = adr; host_wdat = wd;
    host_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (hack_n != h0) begin
        done = 1;
        break;
      end
    end
    host_req = 1'b0;
    slv_noack = 0;
    check("host_done", done, 1);
    if (!done) return;
    check("host_err", last_err, noack);
    check("host_txn_n", txq.size(), 1);
    if (txq.size() > 0) begin
      check("host_adr", txq[0].adr, adr);
      check("host_we", txq[0].we, we);
      if (we) check("host_wdat", txq[0].wdat, wd);
      check("host_tmo", txq[0].tmo, noack);
      if (noack) check("host_tmo_len", txq[0].len, 16);
    end
    m_last_int = 0;
    if (noack) m_terr = 1;
    else if (!we) m_rdat = rd;
    check_model("host");
  endtask

  task automatic int_op(input logic [31:0] rd, input int ws,
                        input bit noack);
    bit done;
    done = 0;
    slv_wait = ws; slv_noack = noack; slv_rdat = rd;
    txq.delete();
    wb_int_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (txq.size() > 0) begin
        done = 1;
        break;
      end
    end
    wb_int_i = 1'b0;
    slv_noack = 0;
    check("int_done", done, 1);
    if (!done) return;
    check("int_adr", txq[0].adr, 8'h08);
    check("int_we", txq[0].we, 0);
    check("int_tmo", txq[0].tmo, noack);
    m_last_int = 1;
    if (noack) m_terr = 1;
    else begin
      m_pend = rd;
      if (m_cnt < 65535) m_cnt++;
    end
    check_model("int");
  endtask

  task automatic rr_op();
    int h0;
    bit exp_int;
    logic [31:0] rd;
    h0 = hack_n;
    rd = $urandom;
    slv_wait = $urandom_range(0, 2);
    slv_noack = 0; slv_rdat = rd;
    txq.delete();
    host_we = 1'b0; host_adr = 8'h0C;
    host_req = 1'b1; wb_int_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (txq.size() >= 4) break;
    end
    host_req = 1'b0; wb_int_i = 1'b0;
    check("rr_n", txq.size(), 4);
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      exp_int = !m_last_int;
      check($sformatf("rr_grant%0d", i), txq[i].adr,
            exp_int ? 32'h08 : 32'h0C);
      if (exp_int) begin
        m_pend = rd;
        m_cnt++;
      end else m_rdat = rd;
      m_last_int = exp_int;
    end
    check("rr_host_acks", hack_n - h0, 2);
    check_model("rr");
  endtask

  initial begin
    int h0;
    bit seen;
    model_reset();
    step(3);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_cfg_done", cfg_done, 0);
    check_model("rst");

    release_and_init();

    // Directed host read with two wait states
    host_op(1'b0, 8'h0C, 32'h0, 32'hA5A5_0003, 2, 1'b0);
    // Directed pending-register read
    int_op(32'h0000_0004, 0, 1'b0);
    check("int_first_cnt", int_cnt, 1);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0)
        int_op($urandom, $urandom_range(0, 4), 1'b0);
      else
        host_op(1'($urandom_range(0, 1)), 8'($urandom),
                $urandom, $urandom, $urandom_range(0, 4), 1'b0);
    end

    rr_op();

    // Host write with no ack, then a normal request
    host_op(1'b1, 8'h20, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);
    host_op(1'b0, 8'h24, 32'h0, $urandom, 1, 1'b0);
    int_op(32'h1234_5678, 0, 1'b1);
    int_op($urandom, 3, 1'b0);

    // Reset during an active host cycle
    slv_wait = 10; slv_noack = 0;
    host_we = 1'b1; host_adr = 8'h30; host_wdat = $urandom;
    host_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (wb_stb_o) begin
        seen = 1;
        break;
      end
    end
    check("rstmid_stb_seen", seen, 1);
    step(2);
    h0 = hack_n;
    rst = 1'b1;
    #1;
    check("rstmid_stb", wb_stb_o, 0);
    check("rstmid_cyc", wb_cyc_o, 0);
    step(2);
    host_req = 1'b0;
    check("rstmid_no_ack", hack_n - h0, 0);
    check("rstmid_cfg_done", cfg_done, 0);
    model_reset();
    check_model("rstmid");
    release_and_init();
    host_op(1'b0, 8'h0C, 32'h0, $urandom, 0, 1'b0);

    check("cyc_eq_stb", cyc_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
